// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage with a single outstanding memory read.
//
// The fetch address sits in pc_reg. Returned words are passed straight through
// to the IF/ID register when the pipeline can accept them. If the pipeline is
// frozen, the word is parked in a hold buffer.
//
// A redirect that arrives while a read is still outstanding parks the stale
// address in drop_addr. The stale word is then absorbed in DROP before the
// unit fetches from the new target.
//
// Optional feature: define IF_FETCH_COUNT_EN to build the handoff counter
// behind fetch_count. Without it, fetch_count is tied to zero and no counter
// register exists.

module if_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        mem_freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] instruction,
    output logic        inst_valid,
    output logic [31:0] fetch_count
);

    // Encoding the IF/ID register treats as a bubble.
    localparam logic [31:0] NOP_WORD = 32'hE000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at pc_reg
        HOLD  = 2'd1,   // fetched word parked in buf, pipeline frozen
        DROP  = 2'd2    // waiting out a read made stale by a redirect
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] drop_addr_q, drop_addr_d;

    logic        go;
    logic        br_acc;
    logic [31:0] pc_seq;

    // Sequential successor of a fetch address; wraps modulo 2^32.
    function automatic logic [31:0] seq_next(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    // Advance and redirect qualifiers: a memory stall blocks everything, branches included.
    always_comb begin
        go     = ~freeze & ~mem_freeze;
        br_acc = branch_taken & ~mem_freeze;
        pc_seq = seq_next(pc_q);
    end

    // The IF/ID register is handed the address after the presented instruction.
    always_comb begin
        PC = pc_seq;
    end

    // Next-state and output decode for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        drop_addr_d = drop_addr_q;
        imem_req    = 1'b1;
        imem_addr   = pc_q;
        instruction = NOP_WORD;
        inst_valid  = 1'b0;

        unique case (state_q)
            FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_q;
                if (br_acc) begin
                    // Redirect: whatever comes back for pc_reg is wrong-path.
                    pc_d = branch_addr;
                    if (!imem_ready) begin
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_ready) begin
                    // The word is shown even when frozen. The frozen
                    // IF/ID register does not load it, and it stays
                    // presented from buf in HOLD.
                    instruction = imem_rdata;
                    inst_valid  = 1'b1;
                    if (go) begin
                        pc_d = pc_seq;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                // No new request until the parked word is consumed.
                imem_req    = 1'b0;
                imem_addr   = pc_q;
                instruction = buf_q;
                inst_valid  = 1'b1;
                if (br_acc) begin
                    pc_d    = branch_addr;
                    state_d = FETCH;
                end else if (go) begin
                    pc_d    = pc_seq;
                    state_d = FETCH;
                end
            end

            DROP: begin
                // Keep the stale request stable until memory completes it.
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (br_acc) begin
                    pc_d = branch_addr;
                end
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase

        // Nothing leaves the stage while reset is asserted.
        if (rst) begin
            instruction = NOP_WORD;
            inst_valid  = 1'b0;
        end
    end

    // FSM and datapath registers. Reset clears the architectural fetch
    // state and abandons any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= 32'h0000_0000;
            buf_q       <= NOP_WORD;
            drop_addr_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            drop_addr_q <= drop_addr_d;
        end
    end

`ifdef IF_FETCH_COUNT_EN
    logic        handoff;
    logic [31:0] fetch_count_q, fetch_count_d;

    // A handoff is a real word accepted by an advancing pipeline with no redirect.
    always_comb begin
        handoff       = inst_valid & go & ~br_acc;
        fetch_count_d = handoff ? fetch_count_q + 32'd1 : fetch_count_q;
    end

    // Free-running handoff counter; wraps at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count_q <= 32'h0000_0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0000_0000;
`endif

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port freeze, input, 1, hazard stall from the hazard unit.
REQ-004 SHALL have port mem_freeze, input, 1, data-cache stall; highest priority.
REQ-005 SHALL have port branch_taken, input, 1, redirect request from the execute stage.
REQ-006 SHALL have port branch_addr, input, 32, redirect target.
REQ-007 SHALL have port imem_rdata, input, 32, instruction memory read data, valid when imem_ready=1.
REQ-008 SHALL have port imem_ready, input, 1, read completion for the current request.
REQ-009 SHALL have port imem_req, output, 1, read request; held with imem_addr stable until imem_ready.
REQ-010 SHALL have port imem_addr, output, 32, fetch address.
REQ-011 SHALL have port PC, output, 32, fetch PC + 4 of the presented instruction, driven to the IF/ID register.
REQ-012 SHALL have port instruction, output, 32, presented instruction; 32'hE0000000 (NOP) when inst_valid=0.
REQ-013 SHALL have port inst_valid, output, 1, instruction holds a real fetched word.
REQ-014 SHALL have port fetch_count, output, 32, count of instructions handed downstream.

Function
REQ-015 SHALL keep pc_reg (32 bit), buf (32 bit), drop_addr (32 bit) and a 3-state FSM: FETCH, HOLD, DROP.
REQ-016 SHALL define go = ~freeze & ~mem_freeze; mem_freeze overrides freeze, and branch_taken is ignored while mem_freeze=1.
REQ-017 FETCH SHALL drive imem_req=1, imem_addr=pc_reg.
REQ-018 FETCH with branch_taken=1 and mem_freeze=0 SHALL load pc_reg<=branch_addr and present NOP; if imem_ready=1 it SHALL discard the returned data and stay in FETCH, else it SHALL set drop_addr<=pc_reg and go to DROP.
REQ-019 FETCH with imem_ready=1, no branch and go=1 SHALL pass imem_rdata through combinationally with inst_valid=1 (zero-cycle latency), set pc_reg<=pc_reg+4 and stay in FETCH.
REQ-020 FETCH with imem_ready=1, no branch and go=0 SHALL set buf<=imem_rdata and go to HOLD; pc_reg unchanged.
REQ-021 FETCH with imem_ready=0 SHALL present NOP with inst_valid=0 and hold all state.
REQ-022 HOLD SHALL drive imem_req=0 and present buf with inst_valid=1; branch_taken (mem_freeze=0) SHALL set pc_reg<=branch_addr and go to FETCH; else go=1 SHALL set pc_reg<=pc_reg+4 and go to FETCH; else hold.
REQ-023 DROP SHALL drive imem_req=1, imem_addr=drop_addr and present NOP; imem_ready=1 SHALL discard data and go to FETCH; a branch in DROP SHALL only update pc_reg.
REQ-024 PC output SHALL equal pc_reg+4 modulo 2^32; pc_reg+4 SHALL wrap 32'hFFFFFFFC to 32'h00000000.
REQ-025 A handoff SHALL be counted when inst_valid=1 and go=1 and no branch is accepted that cycle.

Reset
REQ-026 rst SHALL immediately force pc_reg=0, buf=32'hE0000000, drop_addr=0, state=FETCH, fetch_count=0; outputs: imem_req=1, imem_addr=0, PC=4, instruction=NOP, inst_valid=0.
REQ-027 Reset mid-request SHALL abandon the outstanding request without a DROP; the memory's next imem_ready completes the address-0 request.

Configuration
REQ-028 With macro IF_FETCH_COUNT_EN defined, fetch_count SHALL increment by 1 (wrapping) per handoff per REQ-025; without it fetch_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-029 Reset, memory always ready with word = address: PC/instruction sequence 4/0, 8/4, 12/8 on consecutive cycles, inst_valid=1 each cycle.
REQ-030 freeze=1 for 3 cycles while ready at pc_reg=8: HOLD, instruction=8 stable 3 cycles, imem_req=0; release -> pc_reg=12 next cycle.
REQ-031 imem_ready=0 at pc_reg=16 then branch_taken with branch_addr=0x100: DROP with imem_addr=16 until ready, data discarded, next fetch address 0x100, no NOP counted.
REQ-032 mem_freeze=1 and branch_taken=1 together in HOLD: pc_reg and buf unchanged, branch ignored.
REQ-033 branch_addr=0xFFFFFFFC, ready: PC=0x00000000, next imem_addr=0x00000000.
REQ-034 With IF_FETCH_COUNT_EN, 5 handoffs and 2 frozen cycles -> fetch_count=5; without the macro -> 0.
